// File: rtl/display_pkg.sv
// Shared definitions for the character display write path.
// Contents:
//   COLS, ROWS, FIFO_DEPTH   - screen geometry and TX FIFO size
//   CHAR_SPACE               - VRAM code written when clearing
//   LAST_COL/ROWS_W/LAST_SWEEP - sized constants for comparisons
//   state_e                  - write-sequencer states
//   is_cr()/is_ignored()     - control-character classification
package display_pkg;

  localparam int COLS       = 40;
  localparam int ROWS       = 24;
  localparam int FIFO_DEPTH = 4;

  localparam logic [5:0]  CHAR_SPACE = 6'd32;
  localparam logic [5:0]  LAST_COL   = 6'(COLS - 1);
  localparam logic [4:0]  ROWS_W     = 5'(ROWS);
  localparam logic [10:0] LAST_SWEEP = 11'h7FF;

  localparam logic [7:0] CR_CODE    = 8'h0D;
  localparam logic [7:0] CR_CODE_HI = 8'h8D;
  localparam logic [7:0] IGN_NUL    = 8'h00;
  localparam logic [7:0] IGN_LF     = 8'h0A;
  localparam logic [7:0] IGN_ESC    = 8'h9B;
  localparam logic [7:0] IGN_DEL    = 8'h7F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHAR,
    S_SCROLL,
    S_CLR_ALL
  } state_e;

  // Carriage return in either parity form.
  function automatic logic is_cr(input logic [7:0] d);
    return (d == CR_CODE) || (d == CR_CODE_HI);
  endfunction

  // Codes that home the column but leave VRAM untouched.
  function automatic logic is_ignored(input logic [7:0] d);
    return (d == IGN_NUL) || (d == IGN_LF) || (d == IGN_ESC) || (d == IGN_DEL);
  endfunction

endpackage

// File: rtl/tx_char_fifo.sv
// Small synchronous FIFO buffering CPU TX characters.
// Ports:
//   clk, rst_n      - clock, async active-low reset
//   push, wr_data   - write request (ignored when full)
//   pop             - read request (ignored when empty)
//   flush           - empties the FIFO, wins over push/pop
//   rd_data         - head entry (valid when !empty)
//   full, empty     - occupancy flags
module tx_char_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push && !full)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop  && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/display_write_ctrl.sv
// Sole writer of the 2048x6 character VRAM: prints CPU TX characters,
// advances the cursor, clears the row exposed by a scroll and sweeps the
// whole screen on clear. Exports cursor and scroll window to scan-out.
// Ports:
//   pixel_clock, reset_n  - clock, async active-low reset
//   pixel_clken           - clock enable, all state holds when low
//   cpu_clken, tx_we      - CPU write strobe (rising edge, qualified)
//   tx_data               - CPU character
//   clr_screen            - level request: clear screen, home cursor
//   tx_busy               - TX register cannot accept
//   vram_w_en/addr/din    - one-cycle VRAM write port
//   cursor_addr           - {cur_row, cur_col}
//   start_row             - first visible VRAM row
module display_write_ctrl
  import display_pkg::*;
(
  input  logic        pixel_clock,
  input  logic        reset_n,
  input  logic        pixel_clken,
  input  logic        cpu_clken,
  input  logic        clr_screen,
  input  logic        tx_we,
  input  logic [7:0]  tx_data,
  output logic        tx_busy,
  output logic        vram_w_en,
  output logic [10:0] vram_w_addr,
  output logic [5:0]  vram_din,
  output logic [10:0] cursor_addr,
  output logic [4:0]  start_row
);

  state_e      state_q, state_d;
  logic [7:0]  char_q, char_d;
  logic [4:0]  cur_row_q, cur_row_d;
  logic [5:0]  cur_col_q, cur_col_d;
  logic [4:0]  start_row_q, start_row_d;
  logic [4:0]  end_row_q, end_row_d;
  logic [5:0]  clr_col_q, clr_col_d;
  logic [10:0] sweep_q, sweep_d;
  logic        armed_q, armed_d;
  logic        vram_w_en_q, vram_w_en_d;
  logic [10:0] vram_w_addr_q, vram_w_addr_d;
  logic [5:0]  vram_din_q, vram_din_d;

  logic       fifo_push, fifo_pop, fifo_flush;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       row_adv;
  logic [4:0] next_row;

  tx_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (pixel_clock),
    .rst_n   (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .wr_data (tx_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tx_busy     = fifo_full | (state_q == S_CLR_ALL) | clr_screen;
  assign vram_w_en   = vram_w_en_q;
  assign vram_w_addr = vram_w_addr_q;
  assign vram_din    = vram_din_q;
  assign cursor_addr = {cur_row_q, cur_col_q};
  assign start_row   = start_row_q;

  always_comb begin
    state_d       = state_q;
    char_d        = char_q;
    cur_row_d     = cur_row_q;
    cur_col_d     = cur_col_q;
    start_row_d   = start_row_q;
    end_row_d     = end_row_q;
    clr_col_d     = clr_col_q;
    sweep_d       = sweep_q;
    armed_d       = armed_q;
    vram_w_en_d   = 1'b0;
    vram_w_addr_d = vram_w_addr_q;
    vram_din_d    = vram_din_q;
    fifo_push     = 1'b0;
    fifo_pop      = 1'b0;
    fifo_flush    = 1'b0;
    row_adv       = 1'b0;
    next_row      = cur_row_q + 5'd1;

    if (pixel_clken) begin
      // One push per tx_we pulse; a pulse that meets tx_busy is consumed and lost.
      fifo_push = tx_we & cpu_clken & armed_q & ~tx_busy;
      if (!tx_we)         armed_d = 1'b1;
      else if (cpu_clken) armed_d = 1'b0;

      if (clr_screen) begin
        fifo_flush = 1'b1;
        state_d    = S_CLR_ALL;
        sweep_d    = '0;
        clr_col_d  = '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (!fifo_empty) begin
              char_d   = fifo_rd_data;
              fifo_pop = 1'b1;
              state_d  = S_CHAR;
            end
          end

          S_CHAR: begin
            state_d = S_IDLE;
            if (is_cr(char_q)) begin
              cur_col_d = '0;
              row_adv   = 1'b1;
            end else if (is_ignored(char_q)) begin
              cur_col_d = '0;
            end else begin
              vram_w_en_d   = 1'b1;
              vram_w_addr_d = {cur_row_q, cur_col_q};
              // Bit 6 inverted maps ASCII letters onto the low glyph codes.
              vram_din_d    = {~char_q[6], char_q[4:0]};
              if (cur_col_q == LAST_COL) begin
                cur_col_d = '0;
                row_adv   = 1'b1;
              end else begin
                cur_col_d = cur_col_q + 6'd1;
              end
            end
            if (row_adv) begin
              cur_row_d = next_row;
              // Cursor stepped past the window: slide it and blank the new row.
              if (next_row == end_row_q) begin
                start_row_d = start_row_q + 5'd1;
                end_row_d   = end_row_q + 5'd1;
                clr_col_d   = '0;
                state_d     = S_SCROLL;
              end
            end
          end

          S_SCROLL: begin
            vram_w_en_d   = 1'b1;
            vram_w_addr_d = {cur_row_q, clr_col_q};
            vram_din_d    = CHAR_SPACE;
            if (clr_col_q == LAST_COL) begin
              clr_col_d = '0;
              state_d   = S_IDLE;
            end else begin
              clr_col_d = clr_col_q + 6'd1;
            end
          end

          S_CLR_ALL: begin
            vram_w_en_d   = 1'b1;
            vram_w_addr_d = sweep_q;
            vram_din_d    = CHAR_SPACE;
            if (sweep_q == LAST_SWEEP) begin
              sweep_d     = '0;
              cur_row_d   = '0;
              cur_col_d   = '0;
              start_row_d = '0;
              end_row_d   = ROWS_W;
              state_d     = S_IDLE;
            end else begin
              sweep_d = sweep_q + 11'd1;
            end
          end

          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_CLR_ALL;
      char_q        <= '0;
      cur_row_q     <= '0;
      cur_col_q     <= '0;
      start_row_q   <= '0;
      end_row_q     <= ROWS_W;
      clr_col_q     <= '0;
      sweep_q       <= '0;
      armed_q       <= 1'b1;
      vram_w_en_q   <= 1'b0;
      vram_w_addr_q <= '0;
      vram_din_q    <= '0;
    end else begin
      state_q       <= state_d;
      char_q        <= char_d;
      cur_row_q     <= cur_row_d;
      cur_col_q     <= cur_col_d;
      start_row_q   <= start_row_d;
      end_row_q     <= end_row_d;
      clr_col_q     <= clr_col_d;
      sweep_q       <= sweep_d;
      armed_q       <= armed_d;
      vram_w_en_q   <= vram_w_en_d;
      vram_w_addr_q <= vram_w_addr_d;
      vram_din_q    <= vram_din_d;
    end
  end

endmodule
